// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding and the
// default framing constants used by the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter. Serialises bytes onto tx_o as one start bit, DATA_BITS
// data bits LSB first, an optional parity bit and STOP_BITS stop bits.
// Bit timing comes from baud_tick_i, a one-cycle pulse at OVERSAMPLE times
// the baud rate, shared with the receiver.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   baud_tick_i         oversampled baud tick
//   tx_en_i             1 = new frames may start
//   parity_en_i         1 = append a parity bit (latched per frame)
//   parity_odd_i        1 = odd parity, 0 = even parity (latched per frame)
//   tx_data_i           byte to send
//   tx_valid_i          tx_data_i is valid
//   tx_ready_o          holding register empty
//   tx_o                serial line, idle high, registered
//   tx_busy_o           frame in progress
//   tx_done_o           one-cycle pulse after the last stop bit ends
//
// Handshake: a byte is accepted on any cycle with tx_valid_i && tx_ready_o.
// tx_ready_o is simply "holding register empty" and does not depend on
// tx_en_i, so one byte can always be parked while the line is busy or
// disabled. The holding register drains into the shift register when a
// frame starts, and tx_ready_o rises the cycle after that load.
module uart_tx
#(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE_DEF,
    parameter int DATA_BITS  = uart_pkg::DATA_BITS_DEF,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baud_tick_i,
    input  logic                 tx_en_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(OVERSAMPLE);
    // DATA_BITS (>= 5) always exceeds STOP_BITS (<= 2), so it sizes the bit counter.
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic                 hold_valid_q, hold_valid_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic accept;
    logic bit_end;
    logic load;

    assign accept  = tx_valid_i && !hold_valid_q;
    assign bit_end = baud_tick_i && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = baud_tick_i ? cnt_q + 1'b1 : cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        done_d       = 1'b0;
        load         = 1'b0;
        tx_d         = 1'b1;

        if (accept) begin
            hold_data_d  = tx_data_i;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (hold_valid_q && tx_en_i) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        done_d = 1'b1;
                        // A waiting byte starts on this same bit_end: no idle gap.
                        if (hold_valid_q && tx_en_i) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame load: drain the holding register and freeze the parity
        // configuration. The parity bit is computed here so later changes
        // to parity_odd_i cannot affect the frame in flight.
        if (load) begin
            state_d      = START;
            cnt_d        = '0;
            shift_d      = hold_data_q;
            hold_valid_d = 1'b0;
            par_en_d     = parity_en_i;
            par_bit_d    = (^hold_data_q) ^ parity_odd_i;
        end

        // tx_o is registered, so drive the level belonging to the next state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
        end
    end

    assign tx_ready_o = !hold_valid_q;
    assign tx_o       = tx_q;
    assign tx_busy_o  = (state_q != IDLE);
    assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. Two instances: u_dut1 (8N1 / 8x1 with optional
// parity, tick every cycle) and u_dut2 (two stop bits, tick every 3rd
// cycle). The reference model builds each frame as a list of line levels
// and indexes it by the number of baud ticks seen since the start bit.
module tb_uart_tx;

    localparam int OS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       tick1;
    logic       tick2;
    logic       tx_en;
    logic       par_en;
    logic       par_odd;
    logic [7:0] data;
    logic       valid1;
    logic       valid2;
    logic       dsel;

    logic ready1, tx1, busy1, done1;
    logic ready2, tx2, busy2, done2;

    int checks = 0;
    int errors = 0;
    int tick_ph = 0;

    uart_tx #(.OVERSAMPLE(16), .DATA_BITS(8), .STOP_BITS(1)) u_dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .baud_tick_i  (tick1),
        .tx_en_i      (tx_en),
        .parity_en_i  (par_en),
        .parity_odd_i (par_odd),
        .tx_data_i    (data),
        .tx_valid_i   (valid1),
        .tx_ready_o   (ready1),
        .tx_o         (tx1),
        .tx_busy_o    (busy1),
        .tx_done_o    (done1)
    );

    uart_tx #(.OVERSAMPLE(16), .DATA_BITS(8), .STOP_BITS(2)) u_dut2 (
        .clk_i        (clk),
        .rst_i        (rst),
        .baud_tick_i  (tick2),
        .tx_en_i      (tx_en),
        .parity_en_i  (par_en),
        .parity_odd_i (par_odd),
        .tx_data_i    (data),
        .tx_valid_i   (valid2),
        .tx_ready_o   (ready2),
        .tx_o         (tx2),
        .tx_busy_o    (busy2),
        .tx_done_o    (done2)
    );

    // Monitor view of whichever instance is under test.
    logic mon_tx, mon_done, mon_ready, mon_busy, mon_tick;
    assign mon_tx    = dsel ? tx2    : tx1;
    assign mon_done  = dsel ? done2  : done1;
    assign mon_ready = dsel ? ready2 : ready1;
    assign mon_busy  = dsel ? busy2  : busy1;
    assign mon_tick  = dsel ? tick2  : tick1;

    // Tick for u_dut2: high for one whole cycle out of every three.
    initial begin
        tick2 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_ph = (tick_ph == 2) ? 0 : tick_ph + 1;
            tick2 = (tick_ph == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input string name);
        int cyc;
        cyc  = 0;
        data = d;
        if (dsel) valid2 = 1'b1; else valid1 = 1'b1;
        while (mon_ready !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (mon_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: tx_ready_o=%b, required 1 within 4000 cycles", name, mon_ready);
        end
        @(negedge clk);
        valid1 = 1'b0;
        valid2 = 1'b0;
    endtask

    // Waits for the start bit, then checks every cycle of the frame against
    // the model, and the tx_done_o pulse right after the last tick.
    task automatic check_frame(input logic [7:0] d, input logic pen, input logic podd,
                               input int nstop, input logic flip_cfg, input logic exp_hold,
                               input string name, output int stop_cycles);
        logic exp_q[$];
        int   ones, nbits, ticks, cyc, idx;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            ones = ones + int'(d[i]);
        end
        if (pen) exp_q.push_back(podd ? ((ones % 2) == 0) : ((ones % 2) == 1));
        for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);
        nbits = exp_q.size();
        stop_cycles = 0;

        cyc = 0;
        while (mon_tx !== 1'b0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (mon_tx !== 1'b0) begin
            errors++;
            $display("FAIL %s start: tx_o=%b, required 0 within 2000 cycles", name, mon_tx);
            return;
        end

        ticks = 0;
        cyc   = 0;
        while (ticks < OS * nbits && cyc < 4000) begin
            idx = ticks / OS;
            checks++;
            if (mon_tx !== exp_q[idx]) begin
                errors++;
                $display("FAIL %s bit %0d cycle %0d: tx_o=%b, required %b", name, idx, cyc, mon_tx, exp_q[idx]);
            end
            if (idx >= nbits - nstop) stop_cycles++;
            if (cyc > 0) begin
                checks++;
                if (mon_done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early done cycle %0d: tx_done_o=%b, required 0", name, cyc, mon_done);
                end
            end
            if (exp_hold && idx >= 1) begin
                checks++;
                if (mon_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s held ready cycle %0d: tx_ready_o=%b, required 0", name, cyc, mon_ready);
                end
            end
            if (flip_cfg && cyc == 40) begin
                par_en  = !par_en;
                par_odd = !par_odd;
            end
            if (mon_tick === 1'b1) ticks++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (mon_done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: tx_done_o=%b, required 1", name, mon_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks += 4;
            if (tx1 !== 1'b1)    begin errors++; $display("FAIL reset tx_o: got %b, required 1", tx1); end
            if (ready1 !== 1'b1) begin errors++; $display("FAIL reset tx_ready_o: got %b, required 1", ready1); end
            if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset tx_busy_o: got %b, required 0", busy1); end
            if (done1 !== 1'b0)  begin errors++; $display("FAIL reset tx_done_o: got %b, required 0", done1); end
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_8n1();
        int sc;
        dsel = 1'b0; par_en = 1'b0;
        send_byte(8'hA5, "8n1");
        checks += 2;
        if (tx1 !== 1'b1)  begin errors++; $display("FAIL 8n1 latency N+1: tx_o=%b, required 1", tx1); end
        if (busy1 !== 1'b0) begin errors++; $display("FAIL 8n1 busy N+1: tx_busy_o=%b, required 0", busy1); end
        @(negedge clk);
        checks += 2;
        if (tx1 !== 1'b0)  begin errors++; $display("FAIL 8n1 latency N+2: tx_o=%b, required 0", tx1); end
        if (busy1 !== 1'b1) begin errors++; $display("FAIL 8n1 busy N+2: tx_busy_o=%b, required 1", busy1); end
        check_frame(8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, "8n1_a5", sc);
        checks++;
        if (sc != 16) begin errors++; $display("FAIL 8n1 stop length: %0d cycles, required 16", sc); end
        @(negedge clk);
        checks += 3;
        if (done1 !== 1'b0) begin errors++; $display("FAIL 8n1 done width: tx_done_o=%b, required 0", done1); end
        if (busy1 !== 1'b0) begin errors++; $display("FAIL 8n1 idle busy: tx_busy_o=%b, required 0", busy1); end
        if (tx1 !== 1'b1)   begin errors++; $display("FAIL 8n1 idle line: tx_o=%b, required 1", tx1); end
    endtask

    task automatic test_parity();
        logic [7:0] pd [3];
        logic       po [3];
        int         sc;
        pd[0] = 8'h07; po[0] = 1'b0;
        pd[1] = 8'h07; po[1] = 1'b1;
        pd[2] = 8'h00; po[2] = 1'b0;
        dsel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            par_en = 1'b1; par_odd = po[i];
            send_byte(pd[i], "parity");
            // Case 1 also flips the parity inputs mid-frame; the frame must not change.
            check_frame(pd[i], 1'b1, po[i], 1, (i == 1), 1'b0, "parity", sc);
            par_en = 1'b1;
            @(negedge clk);
        end
        par_en = 1'b0; par_odd = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       pe, po;
        int         sc;
        dsel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom_range(0, 255));
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            par_en = pe; par_odd = po;
            send_byte(d, "random");
            check_frame(d, pe, po, 1, 1'b0, 1'b0, "random", sc);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        par_en = 1'b0; par_odd = 1'b0;
    endtask

    task automatic test_back_to_back();
        int sc;
        dsel = 1'b0;
        fork
            begin
                send_byte(8'h55, "b2b_first");
                send_byte(8'hAA, "b2b_second");
            end
        join_none
        check_frame(8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b1, "b2b_55", sc);
        checks++;
        if (tx1 !== 1'b0) begin errors++; $display("FAIL b2b gap: tx_o=%b after first stop, required 0", tx1); end
        check_frame(8'hAA, 1'b0, 1'b0, 1, 1'b0, 1'b0, "b2b_aa", sc);
        wait fork;
        @(negedge clk);
    endtask

    task automatic test_tx_en();
        int sc;
        dsel = 1'b0;
        tx_en = 1'b0;
        send_byte(8'h3C, "en_off");
        checks++;
        if (ready1 !== 1'b0) begin errors++; $display("FAIL en_off ready: tx_ready_o=%b, required 0", ready1); end
        repeat (30) begin
            @(negedge clk);
            checks += 2;
            if (tx1 !== 1'b1)   begin errors++; $display("FAIL en_off line: tx_o=%b, required 1", tx1); end
            if (busy1 !== 1'b0) begin errors++; $display("FAIL en_off busy: tx_busy_o=%b, required 0", busy1); end
        end
        tx_en = 1'b1;
        @(negedge clk);
        checks++;
        if (tx1 !== 1'b0) begin errors++; $display("FAIL en_on start: tx_o=%b, required 0", tx1); end
        fork
            begin
                repeat (20) @(negedge clk);
                tx_en = 1'b0;
                send_byte(8'h99, "en_mid");
            end
        join_none
        check_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0, "en_3c", sc);
        wait fork;
        repeat (30) begin
            @(negedge clk);
            checks += 3;
            if (tx1 !== 1'b1)    begin errors++; $display("FAIL en_mid line: tx_o=%b, required 1", tx1); end
            if (busy1 !== 1'b0)  begin errors++; $display("FAIL en_mid busy: tx_busy_o=%b, required 0", busy1); end
            if (ready1 !== 1'b0) begin errors++; $display("FAIL en_mid held: tx_ready_o=%b, required 0", ready1); end
        end
        tx_en = 1'b1;
        check_frame(8'h99, 1'b0, 1'b0, 1, 1'b0, 1'b0, "en_99", sc);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, sc;
        dsel = 1'b0;
        send_byte(8'h5A, "rst_mid");
        cyc = 0;
        while (tx1 !== 1'b0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (tx1 !== 1'b0) begin errors++; $display("FAIL rst_mid start: tx_o=%b, required 0", tx1); end
        send_byte(8'hC3, "rst_held");
        repeat (OS * 4 + 4) @(negedge clk);
        checks += 2;
        if (ready1 !== 1'b0) begin errors++; $display("FAIL rst_mid held: tx_ready_o=%b, required 0", ready1); end
        if (busy1 !== 1'b1)  begin errors++; $display("FAIL rst_mid busy: tx_busy_o=%b, required 1", busy1); end
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (tx1 !== 1'b1)    begin errors++; $display("FAIL rst_mid line: tx_o=%b, required 1", tx1); end
        if (busy1 !== 1'b0)  begin errors++; $display("FAIL rst_mid busy after: tx_busy_o=%b, required 0", busy1); end
        if (ready1 !== 1'b1) begin errors++; $display("FAIL rst_mid ready after: tx_ready_o=%b, required 1", ready1); end
        if (done1 !== 1'b0)  begin errors++; $display("FAIL rst_mid done: tx_done_o=%b, required 0", done1); end
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            checks += 2;
            if (tx1 !== 1'b1)   begin errors++; $display("FAIL rst_mid discard: tx_o=%b, required 1", tx1); end
            if (done1 !== 1'b0) begin errors++; $display("FAIL rst_mid no done: tx_done_o=%b, required 0", done1); end
        end
        send_byte(8'h81, "rst_81");
        check_frame(8'h81, 1'b0, 1'b0, 1, 1'b0, 1'b0, "rst_81", sc);
        @(negedge clk);
    endtask

    task automatic test_stop2();
        logic [7:0] d;
        int         sc;
        dsel = 1'b1;
        par_en = 1'b0; par_odd = 1'b0;
        d = 8'($urandom_range(0, 255));
        send_byte(d, "stop2");
        check_frame(d, 1'b0, 1'b0, 2, 1'b0, 1'b0, "stop2", sc);
        checks++;
        if (sc != 96) begin errors++; $display("FAIL stop2 length: %0d cycles high, required 96", sc); end
        par_en = 1'b1; par_odd = 1'b1;
        d = 8'($urandom_range(0, 255));
        send_byte(d, "stop2_par");
        check_frame(d, 1'b1, 1'b1, 2, 1'b0, 1'b0, "stop2_par", sc);
        checks++;
        if (sc != 96) begin errors++; $display("FAIL stop2_par length: %0d cycles high, required 96", sc); end
        par_en = 1'b0; par_odd = 1'b0;
        dsel = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick1 = 1'b1; tx_en = 1'b1;
        par_en = 1'b0; par_odd = 1'b0; data = 8'h00;
        valid1 = 1'b0; valid2 = 1'b0; dsel = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_random();
        test_back_to_back();
        test_tx_en();
        test_reset_mid();
        test_stop2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
